// File: rtl/pocket_seq_if.sv
// pocket_seq_if: control, pattern-write and playback bus of the step sequencer
//   start/stop/len      playback control (master -> sequencer)
//   wr_en/wr_addr/wr_data pattern memory write port (master -> sequencer)
//   keys/playing/step_idx/step_tick/done playback status (sequencer -> master)
interface pocket_seq_if;
    logic       start;
    logic       stop;
    logic [3:0] len;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] keys;
    logic       playing;
    logic [3:0] step_idx;
    logic       step_tick;
    logic       done;
    modport master (output start, stop, len, wr_en, wr_addr, wr_data,
                    input keys, playing, step_idx, step_tick, done);
    modport slave (input start, stop, len, wr_en, wr_addr, wr_data,
                   output keys, playing, step_idx, step_tick, done);
endinterface

// File: rtl/pocket_seq.sv
// pocket_seq: step sequencer playing 4-bit key masks from a 16x4 pattern memory
//   clk, rst_n (sync, active-low); bus: pocket_seq_if.slave (control, write port, status)
//   POCKET_SEQ_LOOP_EN: wrap to step 0 after the last step instead of ending with done
module pocket_seq #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int STEP_MS  = 250,
    parameter int GATE_PCT = 75
) (
    input logic         clk,
    input logic         rst_n,
    pocket_seq_if.slave bus
);
    localparam logic [31:0] STEP_CYCLES = 32'(CLK_FREQ / 1000 * STEP_MS);
    localparam logic [31:0] GATE_CYCLES = STEP_CYCLES * 32'(GATE_PCT) / 32'd100;
    localparam bit          GAP         = GATE_CYCLES < STEP_CYCLES;
    typedef enum logic {IDLE, PLAY} state_t;
    state_t      state, state_nx;
    logic [3:0]  mem [16];
    logic [31:0] cnt, cnt_nx;
    logic [3:0]  idx_q, idx_nx, len_q, len_nx, keys_q, keys_nx, idx_inc;
    logic        tick_q, tick_nx, done_q, done_nx;
    assign idx_inc       = idx_q + 4'd1;
    assign bus.keys      = keys_q;
    assign bus.playing   = state == PLAY;
    assign bus.step_idx  = idx_q;
    assign bus.step_tick = tick_q;
    assign bus.done      = done_q;
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        idx_nx   = idx_q;
        len_nx   = len_q;
        keys_nx  = '0;
        tick_nx  = 1'b0;
        done_nx  = 1'b0;
        // stop outranks start, and start outranks the end-of-run transition
        if (bus.stop) begin
            state_nx = IDLE;
        end else if (bus.start) begin
            state_nx = PLAY;
            idx_nx   = '0;
            len_nx   = bus.len;
            keys_nx  = mem[0];
            tick_nx  = 1'b1;
        end else if (state == PLAY) begin
            cnt_nx  = cnt + 32'd1;
            keys_nx = keys_q;
            if (cnt == STEP_CYCLES - 32'd1) begin
                cnt_nx = '0;
                if (idx_q < len_q) begin
                    idx_nx  = idx_inc;
                    keys_nx = mem[idx_inc];
                    tick_nx = 1'b1;
                end else begin
`ifdef POCKET_SEQ_LOOP_EN
                    idx_nx  = '0;
                    keys_nx = mem[0];
                    tick_nx = 1'b1;
`else
                    state_nx = IDLE;
                    keys_nx  = '0;
                    done_nx  = 1'b1;
`endif
                end
            end else if (GAP && cnt == GATE_CYCLES - 32'd1) begin
                keys_nx = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            len_q  <= '0;
            keys_q <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx_q  <= idx_nx;
            len_q  <= len_nx;
            keys_q <= keys_nx;
            tick_q <= tick_nx;
            done_q <= done_nx;
        end
    end
    // a write landing on the step being loaded is seen only on the next visit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_pocket_seq.sv
// tb_pocket_seq: randomized and directed checks of pocket_seq against a step/gate arithmetic model
module tb_pocket_seq;
    localparam int STEP = 10;
    localparam int GATE = 5;
    typedef struct packed {
        logic [3:0] keys;
        logic       playing;
        logic [3:0] idx;
        logic       tick;
        logic       done;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0][3:0] pat = '0;
    logic [15:0][3:0] pat_l = '0;
    pocket_seq_if bus ();
    pocket_seq_if bus_l ();
    pocket_seq #(.CLK_FREQ(1000), .STEP_MS(10), .GATE_PCT(50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pocket_seq #(.CLK_FREQ(1000), .STEP_MS(10), .GATE_PCT(100)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end
    function automatic exp_t model(int t, int len, int gate, logic [15:0][3:0] p);
        int s = t / STEP;
        int o = t % STEP;
        int n = len + 1;
        exp_t e;
`ifdef POCKET_SEQ_LOOP_EN
        s = s % n;
`endif
        if (s < n) begin
            e.keys = o < gate ? p[s] : 4'd0;
            e.playing = 1'b1;
            e.idx = 4'(s);
            e.tick = o == 0;
            e.done = 1'b0;
        end else begin
            e.keys = 4'd0;
            e.playing = 1'b0;
            e.idx = 4'(len);
            e.tick = 1'b0;
            e.done = t == n * STEP;
        end
        return e;
    endfunction
    function automatic exp_t obs_main();
        return exp_t'({bus.keys, bus.playing, bus.step_idx, bus.step_tick, bus.done});
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int a, input logic [3:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        pat[a] = d;
    endtask
    task automatic go(input int len);
        bus.start = 1'b1;
        bus.len = 4'(len);
        tick();
        bus.start = 1'b0;
    endtask
    task automatic idle();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
    endtask
    task automatic test_reset();
        exp_t o;
        wr(0, 4'hA);
        go(0);
        rst_n = 1'b0;
        tick();
        o = obs_main();
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want %b", o, 11'b0);
        end
        tick();
        rst_n = 1'b1;
        pat = '0;
        tick();
    endtask
    task automatic test_pattern();
        exp_t e, o;
        wr(0, 4'b0001);
        wr(1, 4'b0010);
        wr(2, 4'b0100);
        go(2);
        for (int t = 0; t < 40; t++) begin
            e = model(t, 2, GATE, pat);
            o = obs_main();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pattern t=%0d got %b want %b (keys,playing,idx,tick,done)", t, o, e);
            end
            tick();
        end
        idle();
    endtask
    task automatic test_random();
        exp_t e, o;
        int len, cyc;
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 16; a++) wr(a, 4'($urandom));
            len = $urandom_range(0, 15);
`ifdef POCKET_SEQ_LOOP_EN
            cyc = 2 * (len + 1) * STEP;
`else
            cyc = (len + 1) * STEP + 3;
`endif
            go(len);
            for (int t = 0; t < cyc; t++) begin
                e = model(t, len, GATE, pat);
                o = obs_main();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random r=%0d len=%0d t=%0d got %b want %b", r, len, t, o, e);
                end
                tick();
            end
            idle();
        end
    endtask
    task automatic test_stop();
        exp_t o;
        wr(0, 4'b0001);
        wr(1, 4'b0010);
        wr(2, 4'b0100);
        go(2);
        repeat (13) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        o = obs_main();
        n_tests++;
        if (o !== exp_t'({4'd0, 1'b0, 4'd1, 1'b0, 1'b0})) begin
            n_fail++;
            $display("FAIL mid_stop got %b want %b", o, exp_t'({4'd0, 1'b0, 4'd1, 1'b0, 1'b0}));
        end
        tick();
        n_tests++;
        if (bus.done !== 1'b0 || bus.playing !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_no_done got done=%b playing=%b want 0 0", bus.done, bus.playing);
        end
        go(2);
        tick();
        bus.stop = 1'b1;
        bus.start = 1'b1;
        tick();
        n_tests++;
        if (bus.playing !== 1'b0 || bus.keys !== 4'd0) begin
            n_fail++;
            $display("FAIL stop_start_play got playing=%b keys=%b want 0 0000", bus.playing, bus.keys);
        end
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b0;
        n_tests++;
        if (bus.playing !== 1'b0 || bus.step_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_start_idle got playing=%b tick=%b want 0 0", bus.playing, bus.step_tick);
        end
    endtask
    task automatic test_restart_collision();
        exp_t o;
        go(2);
        repeat (25) tick();
        go(2);
        o = obs_main();
        n_tests++;
        if (o !== model(0, 2, GATE, pat)) begin
            n_fail++;
            $display("FAIL restart got %b want %b", o, model(0, 2, GATE, pat));
        end
        repeat (9) tick();
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 4'b1111;
        tick();
        bus.wr_en = 1'b0;
        n_tests++;
        if (bus.keys !== 4'b0010 || bus.step_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_old got keys=%b idx=%0d want 0010 1", bus.keys, bus.step_idx);
        end
        pat[1] = 4'b1111;
        go(2);
        repeat (10) tick();
        n_tests++;
        if (bus.keys !== 4'b1111 || bus.step_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_new got keys=%b idx=%0d want 1111 1", bus.keys, bus.step_idx);
        end
        idle();
    endtask
    task automatic test_reset_mid();
        exp_t o, e;
        go(2);
        repeat (13) tick();
        rst_n = 1'b0;
        tick();
        o = obs_main();
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got %b want %b", o, 11'b0);
        end
        rst_n = 1'b1;
        pat = '0;
        pat_l = '0;
        tick();
        go(2);
        for (int t = 0; t < 12; t++) begin
            e = model(t, 2, GATE, pat);
            o = obs_main();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_replay t=%0d got %b want %b", t, o, e);
            end
            tick();
        end
        idle();
    endtask
    task automatic test_legato();
        exp_t e, o;
        for (int a = 0; a < 3; a++) begin
            pat_l[a] = 4'($urandom_range(1, 15));
            bus_l.wr_en = 1'b1;
            bus_l.wr_addr = 4'(a);
            bus_l.wr_data = pat_l[a];
            tick();
        end
        bus_l.wr_en = 1'b0;
        bus_l.start = 1'b1;
        bus_l.len = 4'd2;
        tick();
        bus_l.start = 1'b0;
        for (int t = 0; t < 30; t++) begin
            e = model(t, 2, STEP, pat_l);
            o = exp_t'({bus_l.keys, bus_l.playing, bus_l.step_idx, bus_l.step_tick, bus_l.done});
            n_tests++;
            if (o !== e || o.keys == 4'd0) begin
                n_fail++;
                $display("FAIL legato t=%0d got %b want %b", t, o, e);
            end
            tick();
        end
        bus_l.stop = 1'b1;
        tick();
        bus_l.stop = 1'b0;
    endtask
    initial begin
        {bus.start, bus.stop, bus.len, bus.wr_en, bus.wr_addr, bus.wr_data} = '0;
        {bus_l.start, bus_l.stop, bus_l.len, bus_l.wr_en, bus_l.wr_addr, bus_l.wr_data} = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_pattern();
        test_random();
        test_stop();
        test_restart_collision();
        test_reset_mid();
        test_legato();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
